// File: rtl/mel_filter_bank.sv
// mel_filter_bank
// Streaming mel filter bank placed after the FFT. Each accepted complex bin
// is squared into a power value, weighted by the two triangular mel filters
// whose shared interval contains the bin, and accumulated into 47 channels.
// Bin 1023 closes the frame: the channel energies are copied into a shadow
// bank and converted one channel per cycle into 10-bit values. The packed
// 470-bit result is then presented with a one-cycle out_valid pulse.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_re      FFT bin real part, 14-bit two's complement
//   in_im      FFT bin imaginary part, 14-bit two's complement
//   in_valid   bin present this cycle
//   in_num     bin index 0..1023
//   out        channel m on out[10m+9:10m], m = 0..46
//   out_valid  one-cycle pulse, out holds a new frame
//   out_num    frame counter value captured at that frame's end
//
// Build option: define MEL_LOG_EN for log compression ({exponent, 4-bit
// mantissa}); otherwise each channel is min(v >> 22, 1023).
module mel_filter_bank (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [13:0]  in_re,
  input  logic [13:0]  in_im,
  input  logic         in_valid,
  input  logic [9:0]   in_num,
  output logic [469:0] out,
  output logic         out_valid,
  output logic [9:0]   out_num
);

  localparam int unsigned NFILT    = 47;
  localparam int unsigned NINT     = 48;
  localparam logic [9:0]  LAST_BIN = 10'd1023;
  localparam logic [9:0]  BAND_END = 10'd456;

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_EMIT} state_e;

  // Stage 0: power and interval lookup (combinational on the inputs)
  logic signed [27:0] re_x, im_x, re_sq, im_sq;
  logic [27:0] p0;
  logic [5:0]  k0;
  logic [7:0]  wu0;

  assign re_x  = 28'($signed(in_re));
  assign im_x  = 28'($signed(in_im));
  assign re_sq = re_x * re_x;
  assign im_sq = im_x * im_x;
  assign p0    = re_sq + im_sq;

  // Band edges unroll to constants, so each division is by a fixed width.
  always_comb begin : band_lookup
    int unsigned base;
    int unsigned wid;
    base = 0;
    wid  = 0;
    k0   = '0;
    wu0  = '0;
    for (int unsigned k = 0; k < NINT; k++) begin
      wid = 2 + k / 3;
      if (32'(in_num) >= base && 32'(in_num) < base + wid) begin
        k0  = 6'(k);
        wu0 = 8'(((32'(in_num) - base) * 256) / wid);
      end
      base = base + wid;
    end
  end

  // Registers
  logic         v1_q, v1_d, first1_q, first1_d, last1_q, last1_d, last2_q, last2_d;
  logic [27:0]  p1_q, p1_d;
  logic [5:0]   k1_q, k1_d;
  logic [7:0]   wu1_q, wu1_d;
  logic [43:0]  acc_q [NFILT];
  logic [43:0]  acc_d [NFILT];
  logic [35:0]  sh_q [NFILT];
  logic [35:0]  sh_d [NFILT];
  state_e       state_q, state_d;
  logic [5:0]   cnt_q, cnt_d;
  logic [469:0] conv_q, conv_d;
  logic [9:0]   frame_q, frame_d, num_cap_q, num_cap_d;
  logic [469:0] out_q, out_d;
  logic         out_valid_q, out_valid_d;
  logic [9:0]   out_num_q, out_num_d;

  // Stage 1 -> 2 weighting: the falling-edge product is p*256 - p*wu,
  // which equals p*wd without a second multiplier.
  logic [35:0] prod_u, prod_d;
  assign prod_u = 36'(p1_q) * 36'(wu1_q);
  assign prod_d = {p1_q, 8'd0} - prod_u;

  // Channel conversion of the shadow entry selected by cnt_q
  logic [35:0] cv;
  logic [9:0]  ch;
`ifdef MEL_LOG_EN
  logic [5:0]  lead;
  always_comb begin
    cv   = sh_q[cnt_q];
    lead = '0;
    for (int unsigned i = 0; i < 36; i++) begin
      if (cv[i]) lead = 6'(i);
    end
    // Normalising the leading one to bit 35 leaves the mantissa in 34:31,
    // zero-padded automatically for small exponents.
    ch = (cv == '0) ? '0 : {lead, 4'((cv << (6'd35 - lead)) >> 31)};
  end
`else
  logic [13:0] lin;
  always_comb begin
    cv  = sh_q[cnt_q];
    lin = 14'(cv >> 22);
    ch  = (lin > 14'd1023) ? 10'd1023 : lin[9:0];
  end
`endif

  always_comb begin
    logic [43:0] contrib;
    contrib = '0;
    // stage 1 capture
    v1_d     = in_valid && (in_num < BAND_END);
    first1_d = in_valid && (in_num == '0);
    last1_d  = in_valid && (in_num == LAST_BIN);
    p1_d     = p0;
    k1_d     = k0;
    wu1_d    = wu0;
    last2_d  = last1_q;
    frame_d  = frame_q;
    num_cap_d = num_cap_q;
    if (last1_d) begin
      num_cap_d = frame_q;
      frame_d   = frame_q + 10'd1;
    end
    // stage 2 accumulate; bin 0 restarts every filter
    for (int unsigned m = 0; m < NFILT; m++) begin
      contrib = '0;
      if (k1_q == 6'(m))     contrib = contrib + 44'(prod_u);
      if (k1_q == 6'(m + 1)) contrib = contrib + 44'(prod_d);
      acc_d[m] = acc_q[m];
      if (v1_q) acc_d[m] = (first1_q ? '0 : acc_q[m]) + contrib;
      sh_d[m] = last2_q ? acc_q[m][43:8] : sh_q[m];
    end
    // converter FSM
    state_d     = state_q;
    cnt_d       = cnt_q;
    conv_d      = conv_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    out_num_d   = out_num_q;
    unique case (state_q)
      S_IDLE: begin
        if (last2_q) begin
          state_d = S_CONV;
          cnt_d   = '0;
        end
      end
      S_CONV: begin
        for (int unsigned m = 0; m < NFILT; m++) begin
          if (cnt_q == 6'(m)) conv_d[10*m +: 10] = ch;
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(NFILT - 1)) state_d = S_EMIT;
      end
      S_EMIT: begin
        out_d       = conv_q;
        out_num_d   = num_cap_q;
        out_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q        <= 1'b0;
      first1_q    <= 1'b0;
      last1_q     <= 1'b0;
      last2_q     <= 1'b0;
      p1_q        <= '0;
      k1_q        <= '0;
      wu1_q       <= '0;
      for (int unsigned m = 0; m < NFILT; m++) begin
        acc_q[m] <= '0;
        sh_q[m]  <= '0;
      end
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      conv_q      <= '0;
      frame_q     <= '0;
      num_cap_q   <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_num_q   <= '0;
    end else begin
      v1_q        <= v1_d;
      first1_q    <= first1_d;
      last1_q     <= last1_d;
      last2_q     <= last2_d;
      p1_q        <= p1_d;
      k1_q        <= k1_d;
      wu1_q       <= wu1_d;
      for (int unsigned m = 0; m < NFILT; m++) begin
        acc_q[m] <= acc_d[m];
        sh_q[m]  <= sh_d[m];
      end
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      conv_q      <= conv_d;
      frame_q     <= frame_d;
      num_cap_q   <= num_cap_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      out_num_q   <= out_num_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign out_num   = out_num_q;

endmodule

// File: tb/tb_mel_filter_bank.sv
// Self-checking bench for mel_filter_bank. Frames are driven bin by bin with
// optional idle gaps and shuffled bin order; expected outputs come from an
// arithmetic model of the filter bank. Honors MEL_LOG_EN like the design.
module tb_mel_filter_bank;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [13:0]  in_re, in_im;
  logic         in_valid;
  logic [9:0]   in_num;
  logic [469:0] out;
  logic         out_valid;
  logic [9:0]   out_num;

  always #5 clk = ~clk;

  mel_filter_bank dut (
    .clk(clk), .rst_n(rst_n), .in_re(in_re), .in_im(in_im),
    .in_valid(in_valid), .in_num(in_num),
    .out(out), .out_valid(out_valid), .out_num(out_num)
  );

`ifdef MEL_LOG_EN
  localparam logic [9:0] BIN1_CH0 = 10'd112;
  localparam logic [9:0] BIN2_CH0 = 10'd128;
  localparam logic [9:0] BIG_CH0  = 10'd432;
`else
  localparam logic [9:0] BIN1_CH0 = 10'd0;
  localparam logic [9:0] BIN2_CH0 = 10'd0;
  localparam logic [9:0] BIG_CH0  = 10'd32;
`endif

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int exp_pulses = 0;
  int exp_frame = 0;
  int b_edge [49];
  int fre [1024];
  int fim [1024];
  int ord [1024];

  always @(negedge clk) if (out_valid === 1'b1) pulses++;

  task automatic chk(input string tag, input logic [469:0] got, input logic [469:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] compress(input longint unsigned v);
`ifdef MEL_LOG_EN
    int e;
    longint unsigned f;
    if (v == 0) return 10'd0;
    e = 63;
    while (((v >> e) & 64'd1) == 0) e--;
    if (e >= 4) f = (v >> (e - 4)) & 64'd15;
    else        f = (v << (4 - e)) & 64'd15;
    return 10'(longint'(e) * 16 + longint'(f));
`else
    longint unsigned q;
    q = v >> 22;
    return (q > 1023) ? 10'd1023 : 10'(q);
`endif
  endfunction

  function automatic logic [469:0] model_frame();
    longint unsigned acc [47];
    logic [469:0] r;
    longint unsigned p;
    int k, d, w, wu, wd;
    r = '0;
    for (int m = 0; m < 47; m++) acc[m] = 0;
    for (int i = 0; i < 456; i++) begin
      p = longint'(fre[i] * fre[i] + fim[i] * fim[i]);
      k = 0;
      while (!(i >= b_edge[k] && i < b_edge[k+1])) k++;
      d  = i - b_edge[k];
      w  = b_edge[k+1] - b_edge[k];
      wu = (256 * d) / w;
      wd = 256 - wu;
      if (k <= 46) acc[k]   += p * longint'(wu);
      if (k >= 1)  acc[k-1] += p * longint'(wd);
    end
    for (int m = 0; m < 47; m++) r[10*m +: 10] = compress(acc[m] >> 8);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_bin(input int n, input int re, input int im);
    in_valid = 1'b1; in_num = 10'(n); in_re = 14'(re); in_im = 14'(im);
    tick();
    in_valid = 1'b0; in_num = 10'($urandom); in_re = 14'($urandom); in_im = 14'($urandom);
  endtask

  task automatic clear_frame();
    for (int i = 0; i < 1024; i++) begin fre[i] = 0; fim[i] = 0; end
  endtask

  task automatic random_frame(input int sh, input int sparse);
    for (int i = 0; i < 1024; i++) begin
      if (sparse != 0 && $urandom_range(0, 15) != 0) begin fre[i] = 0; fim[i] = 0; end
      else begin
        fre[i] = (int'($urandom_range(0, 16383)) - 8192) >>> sh;
        fim[i] = (int'($urandom_range(0, 16383)) - 8192) >>> sh;
      end
    end
  endtask

  // Sends bins 0..upto-1 in order (bin 0 first, 1023 last when shuffled).
  task automatic run_frame(input int gaps, input int shuffle, input int upto);
    int j, t;
    for (int i = 0; i < 1024; i++) ord[i] = i;
    if (shuffle != 0) begin
      for (int i = 1022; i > 1; i--) begin
        j = $urandom_range(1, i);
        t = ord[i]; ord[i] = ord[j]; ord[j] = t;
      end
    end
    for (int i = 0; i < upto; i++) begin
      if (gaps != 0 && $urandom_range(0, 7) == 0) repeat ($urandom_range(1, 3)) tick();
      send_bin(ord[i], fre[ord[i]], fim[ord[i]]);
    end
  endtask

  task automatic check_frame(input string tag);
    int n;
    logic [469:0] e;
    e = model_frame();
    n = 0;
    while (out_valid !== 1'b1 && n < 200) begin tick(); n++; end
    chk($sformatf("%s_latency", tag), 470'(n), 470'd50);
    chk($sformatf("%s_out", tag), out, e);
    chk($sformatf("%s_num", tag), 470'(out_num), 470'(exp_frame));
    exp_frame = (exp_frame + 1) % 1024;
    exp_pulses++;
    tick();
    chk($sformatf("%s_vld_one_cycle", tag), 470'(out_valid), 470'd0);
    chk($sformatf("%s_hold", tag), out, e);
    chk($sformatf("%s_pulses", tag), 470'(pulses), 470'(exp_pulses));
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    chk($sformatf("%s_out", tag), out, 470'd0);
    chk($sformatf("%s_vld", tag), 470'(out_valid), 470'd0);
    chk($sformatf("%s_num", tag), 470'(out_num), 470'd0);
    tick(); tick();
    rst_n = 1'b1;
    exp_frame = 0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_num = '0; in_re = '0; in_im = '0;
    b_edge[0] = 0;
    for (int k = 0; k < 48; k++) b_edge[k+1] = b_edge[k] + 2 + k / 3;
    #1;
    chk("reset_out", out, 470'd0);
    chk("reset_vld", 470'(out_valid), 470'd0);
    chk("reset_num", 470'(out_num), 470'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // two all-zero frames, out_num 0 then 1
    clear_frame();
    run_frame(0, 0, 1024); check_frame("zero_a");
    run_frame(1, 0, 1024); check_frame("zero_b");

    // single bin 1, re = 16
    clear_frame(); fre[1] = 16;
    run_frame(0, 0, 1024); check_frame("bin1");
    chk("bin1_ch0", 470'(out[9:0]), 470'(BIN1_CH0));

    // single bin 2, re = 16
    clear_frame(); fre[2] = 16;
    run_frame(1, 0, 1024); check_frame("bin2");
    chk("bin2_ch0", 470'(out[9:0]), 470'(BIN2_CH0));
    chk("bin2_ch1", 470'(out[19:10]), 470'd0);

    // full-scale energy above the last band edge only
    clear_frame();
    for (int i = 456; i < 1024; i++) begin fre[i] = -8192; fim[i] = -8192; end
    run_frame(1, 0, 1024); check_frame("high_bins");
    chk("high_bins_zero", out, 470'd0);

    // full-scale bin 2
    clear_frame(); fre[2] = -8192; fim[2] = -8192;
    run_frame(0, 0, 1024); check_frame("big");
    chk("big_ch0", 470'(out[9:0]), 470'(BIG_CH0));

    // randomized frames: dense/sparse, varied amplitude, gaps, shuffled order
    for (int f = 0; f < 5; f++) begin
      random_frame((f == 0) ? 0 : int'($urandom_range(0, 9)), f % 2);
      run_frame(1, (f >= 3) ? 1 : 0, 1024);
      check_frame($sformatf("rand%0d", f));
    end

    // reset during conversion: no stale pulse afterwards
    random_frame(0, 0);
    run_frame(0, 0, 1024);
    repeat (20) tick();
    do_reset("rst_conv");
    repeat (70) tick();
    chk("rst_conv_nopulse", 470'(pulses), 470'(exp_pulses));

    // reset in the middle of a frame, then a clean frame
    random_frame(0, 0);
    run_frame(0, 0, 501);
    do_reset("rst_mid");
    repeat (60) tick();
    chk("rst_mid_nopulse", 470'(pulses), 470'(exp_pulses));
    clear_frame(); fre[1] = 16;
    run_frame(0, 0, 1024); check_frame("after_rst");
    chk("after_rst_ch0", 470'(out[9:0]), 470'(BIN1_CH0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
